ctr_table_updater: RTL and testbench
====================================

Name: ctr_table_updater

Overview:
- Client-side controller for the 512 x 16-bit masked-write counter array (8 lanes x 2-bit saturating counters per row).
- Owns both array ports: sweeps the table to a known value after reset, then serves predict reads and read-modify-write counter updates.
- Sits between the BPU predictor stage (predict reads) and the update/commit path (training requests).

Parameters:
- ADDR_W, 9, row address width (DEPTH = 512)
- NUM_WAYS, 8, counters per row
- CTR_W, 2, counter width; row width = NUM_WAYS*CTR_W = 16
- INIT_CTR, 2'b01, counter value written to every lane during the init sweep (weakly not-taken)

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high
- io_init_done  out  1  high once the init sweep has completed
- io_rd_en  in  1  predict read request
- io_rd_addr  in  9  predict read row
- io_rd_data  out  16  predict read row data, valid the cycle after io_rd_en
- io_req_valid  in  1  update request valid
- io_req_ready  out  1  update request accepted when valid & ready
- io_req_addr  in  9  row to update
- io_req_way  in  3  lane to update
- io_req_taken  in  1  1 = saturating increment, 0 = saturating decrement
- sram_r_en  out  1  array read enable
- sram_r_addr  out  9  array read address
- sram_r_data  in  16  array read data, one cycle after sram_r_en
- sram_w_en  out  1  array write enable
- sram_w_addr  out  9  array write address
- sram_w_data  out  16  array write data
- sram_w_mask  out  8  per-lane write mask (bit i covers bits 2i+1:2i)

Behaviour:
- Reset values: io_init_done=0, io_req_ready=0, sram_r_en=0, sram_w_en=0, all pipeline valids=0, forward-register valid=0, init counter=0.
- FSM states: INIT and RUN.
- INIT:
  - Each cycle: sram_w_en=1, sram_w_addr=init counter, sram_w_data=INIT_CTR replicated into all 8 lanes, sram_w_mask=8'hFF; counter increments.
  - After the write to address 511 (512 cycles total), move to RUN. io_init_done=1 from the next cycle.
  - In INIT: io_req_ready=0, sram_r_en=0, io_rd_en ignored, io_rd_data undefined.
- RUN, read-port arbitration:
  - Predict wins: if io_rd_en then sram_r_en=1, sram_r_addr=io_rd_addr.
  - io_req_ready = init_done & !io_rd_en.
  - io_rd_data = sram_r_data in the following cycle, unmodified (no forwarding on the predict path).
- RUN, update pipeline; throughput 1 per cycle, no stalls:
  - Stage U0 (cycle t): on handshake, sram_r_en=1, sram_r_addr=io_req_addr; register addr, way and taken into U1.
  - Stage U1 (cycle t+1): take lane L=way of the row (sram_r_data, after forwarding).
    - taken: new = (L==3) ? 3 : L+1.
    - not taken: new = (L==0) ? 0 : L-1.
  - Write in the same cycle, combinationally: sram_w_en=1, sram_w_addr=addr, sram_w_mask=onehot(way), sram_w_data=new in lane way and 0 in other lanes.
  - Update latency: the write commits at the end of cycle t+1.
- Forwarding: removes any dependence on the array's read-during-write behaviour.
  - Each U1 write is captured into the forward register {valid, addr, way, new} at the end of its cycle.
  - In U1, if forward valid & fwd.addr==U1.addr, replace lane fwd.way of sram_r_data with fwd.new before the compute.
  - Forward valid clears on any cycle with no U1 write.
- Simultaneous events: a predict read and a U1 write in the same cycle are both legal (separate ports).
- Reset asserted mid-operation (any state): in-flight updates are dropped with no write. The block returns to INIT with the counter at 0 and re-sweeps the full table.

Decomposition:
- Package ctr_table_pkg: ADDR_W, NUM_WAYS, CTR_W, ROW_W, INIT_CTR, the state enum {INIT, RUN}, and function sat_update(ctr, taken).
- One sub-module: ctr_lane_update. Combinational: takes row, way, taken, forward hit/way/value; returns the new counter plus the write data and mask.

Test Plan:
- Reset, hold all inputs low -> 512 consecutive writes, addr 0..511, data 16'h5555, mask 8'hFF; io_init_done rises on cycle 513; io_req_ready=0 throughout the sweep.
- After init: req addr=7, way=3, taken=1 -> read addr 7 in cycle t; in t+1, write addr 7, mask 8'h08, data 16'h0080 (lane 3 = 2); a later predict read of addr 7 returns 16'h5595.
- Four back-to-back taken reqs on addr 7, way 3 from value 1 -> written lane values 2,3,3,3 (forwarding exercised). Repeat with not-taken from 1 -> 0,0,0,0.
- Back-to-back reqs on addr 7: way 0 taken, then way 1 not taken -> writes mask 8'h01 value 2, then mask 8'h02 value 0; the forward hit must not corrupt lane 1.
- io_rd_en=1 for 3 cycles while io_req_valid=1 -> io_req_ready=0 for those cycles; no update read is issued; the request is accepted in the first cycle after io_rd_en drops.
- Assert reset at sweep address 200 and again while an update is in U1 -> no write from the dropped update; the sweep restarts at addr 0; io_init_done=0 until 512 new writes have completed.

Source files
------------

// File: rtl/ctr_table_pkg.sv
// Shared widths, FSM states and the 2-bit saturating counter step for the counter table client.
package ctr_table_pkg;
    localparam int ADDR_W   = 9;
    localparam int NUM_WAYS = 8;
    localparam int CTR_W    = 2;
    localparam int ROW_W    = NUM_WAYS * CTR_W;
    localparam int WAY_W    = $clog2(NUM_WAYS);

    localparam logic [CTR_W-1:0]  INIT_CTR  = 2'b01;
    localparam logic [CTR_W-1:0]  CTR_ONE   = 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    function automatic logic [CTR_W-1:0] sat_update(input logic [CTR_W-1:0] ctr,
                                                    input logic             taken);
        logic [CTR_W-1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != '1) res = ctr + CTR_ONE;
        end else begin
            if (ctr != '0) res = ctr - CTR_ONE;
        end
        return res;
    endfunction
endpackage

// File: rtl/ctr_lane_update.sv
// Applies the pending forward to a fetched row, steps the selected lane and builds the masked write.
// Purely combinational; no flow control.
module ctr_lane_update
    import ctr_table_pkg::*;
(
    input  logic [ROW_W-1:0]    row,
    input  logic [WAY_W-1:0]    way,
    input  logic                taken,
    input  logic                fwd_hit,
    input  logic [WAY_W-1:0]    fwd_way,
    input  logic [CTR_W-1:0]    fwd_ctr,
    output logic [CTR_W-1:0]    new_ctr,
    output logic [ROW_W-1:0]    w_data,
    output logic [NUM_WAYS-1:0] w_mask
);
    logic [ROW_W-1:0] row_fwd;

    always_comb begin
        row_fwd = row;
        // Only the forwarded lane is patched; other lanes of the stale row are already correct.
        if (fwd_hit) row_fwd[fwd_way*CTR_W +: CTR_W] = fwd_ctr;
        new_ctr = sat_update(row_fwd[way*CTR_W +: CTR_W], taken);
        w_data = '0;
        w_data[way*CTR_W +: CTR_W] = new_ctr;
        w_mask = '0;
        w_mask[way] = 1'b1;
    end
endmodule

// File: rtl/ctr_table_updater.sv
// Sweeps the 512x16 counter array after reset, then serves predict reads and 2-stage counter RMW.
// Update write one cycle after accept; predict reads take priority and deassert io_req_ready.
module ctr_table_updater
    import ctr_table_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    output logic                io_init_done,
    input  logic                io_rd_en,
    input  logic [ADDR_W-1:0]   io_rd_addr,
    output logic [ROW_W-1:0]    io_rd_data,
    input  logic                io_req_valid,
    output logic                io_req_ready,
    input  logic [ADDR_W-1:0]   io_req_addr,
    input  logic [WAY_W-1:0]    io_req_way,
    input  logic                io_req_taken,
    output logic                sram_r_en,
    output logic [ADDR_W-1:0]   sram_r_addr,
    input  logic [ROW_W-1:0]    sram_r_data,
    output logic                sram_w_en,
    output logic [ADDR_W-1:0]   sram_w_addr,
    output logic [ROW_W-1:0]    sram_w_data,
    output logic [NUM_WAYS-1:0] sram_w_mask
);
    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   init_cnt_q;
    logic                u1_vld_q, u1_taken_q;
    logic [ADDR_W-1:0]   u1_addr_q;
    logic [WAY_W-1:0]    u1_way_q;
    logic                fwd_vld_q;
    logic [ADDR_W-1:0]   fwd_addr_q;
    logic [WAY_W-1:0]    fwd_way_q;
    logic [CTR_W-1:0]    fwd_ctr_q;
    logic [CTR_W-1:0]    new_ctr;
    logic [ROW_W-1:0]    upd_data;
    logic [NUM_WAYS-1:0] upd_mask;
    logic                sweep, run, req_fire, u1_wr, fwd_hit;

    // Gating with reset drops an in-flight U1 write the moment reset is seen.
    assign sweep    = (state_q == INIT) && !reset;
    assign run      = (state_q == RUN) && !reset;
    assign req_fire = io_req_valid && io_req_ready;
    assign u1_wr    = run && u1_vld_q;
    assign fwd_hit  = fwd_vld_q && (fwd_addr_q == u1_addr_q);

    assign io_init_done = run;
    assign io_req_ready = run && !io_rd_en;
    assign io_rd_data   = sram_r_data;

    ctr_lane_update u_lane (
        .row     (sram_r_data),
        .way     (u1_way_q),
        .taken   (u1_taken_q),
        .fwd_hit (fwd_hit),
        .fwd_way (fwd_way_q),
        .fwd_ctr (fwd_ctr_q),
        .new_ctr (new_ctr),
        .w_data  (upd_data),
        .w_mask  (upd_mask)
    );

    always_comb begin
        state_d     = state_q;
        sram_r_en   = run && (io_rd_en || io_req_valid);
        sram_r_addr = io_rd_en ? io_rd_addr : io_req_addr;
        sram_w_en   = 1'b0;
        sram_w_addr = '0;
        sram_w_data = '0;
        sram_w_mask = '0;
        if (sweep) begin
            sram_w_en   = 1'b1;
            sram_w_addr = init_cnt_q;
            sram_w_data = {NUM_WAYS{INIT_CTR}};
            sram_w_mask = '1;
            if (init_cnt_q == LAST_ADDR) state_d = RUN;
        end else if (u1_wr) begin
            sram_w_en   = 1'b1;
            sram_w_addr = u1_addr_q;
            sram_w_data = upd_data;
            sram_w_mask = upd_mask;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            u1_vld_q   <= 1'b0;
            fwd_vld_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            u1_vld_q <= req_fire;
            fwd_vld_q <= u1_wr;
            if (sweep) init_cnt_q <= init_cnt_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (req_fire) begin
            u1_addr_q  <= io_req_addr;
            u1_way_q   <= io_req_way;
            u1_taken_q <= io_req_taken;
        end
        if (u1_wr) begin
            fwd_addr_q <= u1_addr_q;
            fwd_way_q  <= u1_way_q;
            fwd_ctr_q  <= new_ctr;
        end
    end
endmodule

// File: tb/tb_ctr_table_updater.sv
// Bench for ctr_table_updater: read-first array model, write/predict scoreboard, directed vectors.
module tb_ctr_table_updater;
    logic        clock = 1'b0;
    logic        reset;
    logic        io_init_done;
    logic        io_rd_en;
    logic [8:0]  io_rd_addr;
    logic [15:0] io_rd_data;
    logic        io_req_valid;
    logic        io_req_ready;
    logic [8:0]  io_req_addr;
    logic [2:0]  io_req_way;
    logic        io_req_taken;
    logic        sram_r_en;
    logic [8:0]  sram_r_addr;
    logic [15:0] sram_r_data = 16'h0000;
    logic        sram_w_en;
    logic [8:0]  sram_w_addr;
    logic [15:0] sram_w_data;
    logic [7:0]  sram_w_mask;

    always #5 clock = ~clock;

    ctr_table_updater dut (
        .clock        (clock),
        .reset        (reset),
        .io_init_done (io_init_done),
        .io_rd_en     (io_rd_en),
        .io_rd_addr   (io_rd_addr),
        .io_rd_data   (io_rd_data),
        .io_req_valid (io_req_valid),
        .io_req_ready (io_req_ready),
        .io_req_addr  (io_req_addr),
        .io_req_way   (io_req_way),
        .io_req_taken (io_req_taken),
        .sram_r_en    (sram_r_en),
        .sram_r_addr  (sram_r_addr),
        .sram_r_data  (sram_r_data),
        .sram_w_en    (sram_w_en),
        .sram_w_addr  (sram_w_addr),
        .sram_w_data  (sram_w_data),
        .sram_w_mask  (sram_w_mask)
    );

    // Read-first array: a read colliding with a write returns the old row.
    logic [15:0] mem [0:511];
    initial for (int i = 0; i < 512; i++) mem[i] = 16'hAAAA;
    always @(posedge clock) begin
        if (sram_r_en) sram_r_data <= mem[sram_r_addr];
        if (sram_w_en)
            for (int i = 0; i < 8; i++)
                if (sram_w_mask[i]) mem[sram_w_addr][2*i +: 2] <= sram_w_data[2*i +: 2];
    end

    typedef struct packed {
        logic [8:0]  addr;
        logic [15:0] data;
        logic [7:0]  mask;
    } wr_t;

    wr_t         exp_wr[$];
    logic [15:0] exp_rd[$];
    int          checks = 0;
    int          failures = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endfunction

    logic rd_pend = 1'b0;
    always @(negedge clock) begin
        wr_t w, got;
        if (sram_w_en) begin
            got = '{addr: sram_w_addr, data: sram_w_data, mask: sram_w_mask};
            if (exp_wr.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write act=%0h exp=none", got);
            end else begin
                w = exp_wr.pop_front();
                chk("write", 64'(got), 64'(w));
            end
        end
        if (rd_pend) begin
            if (exp_rd.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_predict act=%0h exp=none", io_rd_data);
            end else begin
                chk("predict_data", 64'(io_rd_data), 64'(exp_rd.pop_front()));
            end
        end
        rd_pend = io_rd_en && io_init_done;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        io_rd_en = 0; io_rd_addr = 0; io_req_valid = 0;
        io_req_addr = 0; io_req_way = 0; io_req_taken = 0;
    endtask

    task automatic apply_reset(input int n);
        reset = 1;
        idle_inputs();
        exp_wr.delete();
        @(negedge clock);
        chk("rst_init_done", 64'(io_init_done), 64'd0);
        chk("rst_req_ready", 64'(io_req_ready), 64'd0);
        chk("rst_r_en", 64'(sram_r_en), 64'd0);
        chk("rst_w_en", 64'(sram_w_en), 64'd0);
        repeat (n) tick();
        reset = 0;
    endtask

    task automatic sweep_check(input int n);
        for (int a = 0; a < 512; a++) exp_wr.push_back('{addr: 9'(a), data: 16'h5555, mask: 8'hFF});
        for (int c = 1; c <= n; c++) begin
            @(negedge clock);
            chk("sweep_ready", 64'(io_req_ready), 64'd0);
            chk("sweep_done_low", 64'(io_init_done), 64'd0);
            tick();
        end
        if (n == 512) begin
            @(negedge clock);
            chk("init_done_rise", 64'(io_init_done), 64'd1);
            chk("sweep_drained", 64'(exp_wr.size()), 64'd0);
            tick();
        end
    endtask

    task automatic issue_req(input logic [8:0] a, input logic [2:0] w, input logic t,
                             input logic [15:0] d, input logic [7:0] m, input bit exp_write);
        io_req_valid = 1; io_req_addr = a; io_req_way = w; io_req_taken = t;
        if (exp_write) exp_wr.push_back('{addr: a, data: d, mask: m});
        @(negedge clock);
        chk("req_ready", 64'(io_req_ready), 64'd1);
        chk("u0_read", 64'({sram_r_en, sram_r_addr}), 64'({1'b1, a}));
        tick();
        io_req_valid = 0;
    endtask

    task automatic predict(input logic [8:0] a, input logic [15:0] d);
        io_rd_en = 1; io_rd_addr = a;
        exp_rd.push_back(d);
        tick();
        io_rd_en = 0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1;
        idle_inputs();
        apply_reset(3);
        sweep_check(512);

        // Single taken update, then read back.
        issue_req(9'd7, 3'd3, 1'b1, 16'h0080, 8'h08, 1);
        tick();
        predict(9'd7, 16'h5595);

        // Back-to-back chain on one lane: 2->1, up to 3 and saturate, down to 0 and saturate.
        issue_req(9'd7, 3'd3, 1'b0, 16'h0040, 8'h08, 1);
        issue_req(9'd7, 3'd3, 1'b1, 16'h0080, 8'h08, 1);
        issue_req(9'd7, 3'd3, 1'b1, 16'h00C0, 8'h08, 1);
        issue_req(9'd7, 3'd3, 1'b1, 16'h00C0, 8'h08, 1);
        issue_req(9'd7, 3'd3, 1'b1, 16'h00C0, 8'h08, 1);
        issue_req(9'd7, 3'd3, 1'b0, 16'h0080, 8'h08, 1);
        issue_req(9'd7, 3'd3, 1'b0, 16'h0040, 8'h08, 1);
        issue_req(9'd7, 3'd3, 1'b0, 16'h0000, 8'h08, 1);
        issue_req(9'd7, 3'd3, 1'b0, 16'h0000, 8'h08, 1);
        issue_req(9'd7, 3'd3, 1'b0, 16'h0000, 8'h08, 1);
        issue_req(9'd7, 3'd3, 1'b0, 16'h0000, 8'h08, 1);
        tick();
        predict(9'd7, 16'h5515);

        // Same row, different lanes back to back: forward must only patch lane 0.
        issue_req(9'd7, 3'd0, 1'b1, 16'h0002, 8'h01, 1);
        issue_req(9'd7, 3'd1, 1'b0, 16'h0000, 8'h02, 1);
        tick();
        predict(9'd7, 16'h5512);

        // Predict reads hold off a pending update for three cycles.
        io_req_valid = 1; io_req_addr = 9'd9; io_req_way = 3'd2; io_req_taken = 1'b1;
        for (int c = 0; c < 3; c++) begin
            io_rd_en = 1; io_rd_addr = 9'd20;
            exp_rd.push_back(16'h5555);
            @(negedge clock);
            chk("stall_ready", 64'(io_req_ready), 64'd0);
            chk("stall_raddr", 64'({sram_r_en, sram_r_addr}), 64'({1'b1, 9'd20}));
            tick();
        end
        io_rd_en = 0;
        issue_req(9'd9, 3'd2, 1'b1, 16'h0020, 8'h04, 1);
        tick();
        predict(9'd9, 16'h5565);

        // Reset in the middle of the sweep, then during a U1 write.
        apply_reset(2);
        sweep_check(200);
        apply_reset(2);
        sweep_check(512);
        issue_req(9'd7, 3'd0, 1'b1, 16'h0000, 8'h00, 0);
        apply_reset(2);
        sweep_check(512);
        predict(9'd7, 16'h5555);
        issue_req(9'd7, 3'd5, 1'b0, 16'h0000, 8'h20, 1);
        tick();
        predict(9'd7, 16'h5155);

        tick();
        chk("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
        chk("rd_queue_empty", 64'(exp_rd.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
